ctrl_ramdrv_ringaddr: RTL

CTRL_RAMDRV_RINGADDR -- requirements
Module: ctrl_ramdrv_ringaddr

---
 rtl/ctrl_ramdrv_pkg.sv | 28 ++
 rtl/ctrl_ramdrv_ringaddr_if.sv | 34 +++
 rtl/ctrl_ramdrv_chctx.sv | 50 +++++
 rtl/ctrl_ramdrv_ringaddr.sv | 100 ++++++++++
 4 files changed

// File: rtl/ctrl_ramdrv_pkg.sv
// Shared types for the ring-buffer RAM address driver: FSM states, per-channel
// context record and the ring index step.
package ctrl_ramdrv_pkg;

    // Context fields are kept at a fixed width; modules truncate to their address width.
    localparam int unsigned CTX_AW = 32;

    typedef logic [CTX_AW-1:0] ctx_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        ctx_word_t base;
        ctx_word_t len;
        ctx_word_t head;
    } ch_ctx_t;

    localparam ch_ctx_t CTX_RESET = '{base: '0, len: ctx_word_t'(1), head: '0};

    function automatic ctx_word_t ring_next(input ctx_word_t idx, input ctx_word_t len);
        return (idx == len - ctx_word_t'(1)) ? '0 : idx + ctx_word_t'(1);
    endfunction

endpackage

// File: rtl/ctrl_ramdrv_ringaddr_if.sv
// Control/status bundle between a ring-buffer user (master) and the address driver (slave).
interface ctrl_ramdrv_ringaddr_if #(
    parameter int unsigned DATA_ADDRESS_WIDTH = 12,
    parameter int unsigned CH_NUM             = 2
);
    localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic [CH_W-1:0]               ch_sel;
    logic                          cfg_we;
    logic [DATA_ADDRESS_WIDTH-1:0] base_ptr;
    logic [DATA_ADDRESS_WIDTH-1:0] ring_len;
    logic                          adv;
    logic                          start;
    logic                          cnt;
    logic [DATA_ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_ADDRESS_WIDTH-1:0] addr;
    logic                          addr_vld;
    logic                          wrap;
    logic                          last;
    logic                          done;
    logic                          busy;
    logic                          cfg_err;

    modport master (
        output ch_sel, cfg_we, base_ptr, ring_len, adv, start, cnt,
        input  wr_addr, addr, addr_vld, wrap, last, done, busy, cfg_err
    );

    modport slave (
        input  ch_sel, cfg_we, base_ptr, ring_len, adv, start, cnt,
        output wr_addr, addr, addr_vld, wrap, last, done, busy, cfg_err
    );

endinterface

// File: rtl/ctrl_ramdrv_chctx.sv
// Per-channel ring context (base, length, write head) with head advance and
// configuration load; presents the context of the selected channel.
module ctrl_ramdrv_chctx
    import ctrl_ramdrv_pkg::*;
#(
    parameter int unsigned DATA_ADDRESS_WIDTH = 12,
    parameter int unsigned CH_NUM             = 2,
    parameter int unsigned CH_W               = 1
) (
    input  logic                          clk,
    input  logic                          clr_n,
    input  logic [CH_W-1:0]               ch_sel,
    input  logic                          cfg_we,
    input  logic [DATA_ADDRESS_WIDTH-1:0] base_ptr,
    input  logic [DATA_ADDRESS_WIDTH-1:0] ring_len,
    input  logic                          adv,
    output ch_ctx_t                       sel_ctx
);

    ch_ctx_t ctx [CH_NUM];

    // NOTE: this small context file is reset register by register because a
    // channel must be usable (len=1) straight out of reset; a RAM macro could not be.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(CH_NUM); i++) ctx[i] <= CTX_RESET;
        end else begin
            for (int i = 0; i < int'(CH_NUM); i++) begin
                if (ch_sel == CH_W'(i)) begin
                    if (cfg_we) begin
                        ctx[i].base <= ctx_word_t'(base_ptr);
                        ctx[i].len  <= ctx_word_t'(ring_len);
                        ctx[i].head <= '0;
                    end else if (adv) begin
                        ctx[i].head <= ring_next(ctx[i].head, ctx[i].len);
                    end
                end
            end
        end
    end

    // NOTE: default assigned first so an unmatched ch_sel cannot infer a latch.
    always_comb begin
        sel_ctx = CTX_RESET;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (ch_sel == CH_W'(i)) sel_ctx = ctx[i];
        end
    end

endmodule

// File: rtl/ctrl_ramdrv_ringaddr.sv
// Ring-buffer RAM address driver: per-channel write head plus a burst reader
// issuing len addresses from the head. Define RAMDRV_TRISTATE_EN to float addr when idle.
module ctrl_ramdrv_ringaddr
    import ctrl_ramdrv_pkg::*;
#(
    parameter int unsigned DATA_ADDRESS_WIDTH = 12,
    parameter int unsigned CH_NUM             = 2
) (
    input logic                   clk,
    input logic                   clr_n,
    ctrl_ramdrv_ringaddr_if.slave bus
);

    localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    state_t    state;
    ctx_word_t run_base;
    ctx_word_t run_len;
    ctx_word_t index;
    ctx_word_t tap;
    logic      cfg_err_q;

    ch_ctx_t   sel_ctx;
    ctx_word_t start_idx;
    logic      ch_ok;
    logic      cfg_ok;

    assign ch_ok  = 32'(bus.ch_sel) < CH_NUM;
    assign cfg_ok = bus.cfg_we && ch_ok && (state == IDLE) && (bus.ring_len != '0);

    ctrl_ramdrv_chctx #(
        .DATA_ADDRESS_WIDTH(DATA_ADDRESS_WIDTH),
        .CH_NUM            (CH_NUM),
        .CH_W              (CH_W)
    ) u_chctx (
        .clk     (clk),
        .clr_n   (clr_n),
        .ch_sel  (bus.ch_sel),
        .cfg_we  (cfg_ok),
        .base_ptr(bus.base_ptr),
        .ring_len(bus.ring_len),
        .adv     (bus.adv),
        .sel_ctx (sel_ctx)
    );

    // A same-cycle adv means the newest sample is already in the ring, so the burst starts past it.
    assign start_idx = bus.adv ? ring_next(sel_ctx.head, sel_ctx.len) : sel_ctx.head;

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            run_base  <= '0;
            run_len   <= ctx_word_t'(1);
            index     <= '0;
            tap       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && !cfg_ok;
            unique case (state)
                IDLE: begin
                    if (bus.start && ch_ok) begin
                        run_base <= sel_ctx.base;
                        run_len  <= sel_ctx.len;
                        index    <= start_idx;
                        tap      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bus.cnt) begin
                        index <= ring_next(index, run_len);
                        tap   <= tap + ctx_word_t'(1);
                        if (tap == run_len - ctx_word_t'(1)) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [DATA_ADDRESS_WIDTH-1:0] rd_addr;

    assign rd_addr      = DATA_ADDRESS_WIDTH'(run_base + index);
    assign bus.wr_addr  = DATA_ADDRESS_WIDTH'(sel_ctx.base + sel_ctx.head);
    assign bus.addr_vld = (state == RUN);
    assign bus.wrap     = (state == RUN) && (index == run_len - ctx_word_t'(1));
    assign bus.last     = (state == RUN) && (tap == run_len - ctx_word_t'(1));
    assign bus.done     = (state == DONE);
    assign bus.busy     = (state != IDLE);
    assign bus.cfg_err  = cfg_err_q;

`ifdef RAMDRV_TRISTATE_EN
    assign bus.addr = (state == RUN) ? rd_addr : 'z;
`else
    assign bus.addr = (state == RUN) ? rd_addr : '0;
`endif

endmodule
